iter_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide execution unit for the multicycle core; successor to the single-cycle MUL path decoded from Instr[7:4]==4'b1001.
- Supports low multiply, long unsigned/signed multiply, and unsigned/signed divide at a generic WIDTH.
- Processes one bit per cycle with a start/busy/done handshake; the controller stalls in an execute state until done.
- Results go to the result mux and flags go to the condition logic, in the same order as ALUFlags.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_negate.sv | 15 +
 rtl/iter_muldiv_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, flag indices.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULL = 3'b001;
    localparam logic [2:0] OP_SMULL = 3'b010;
    localparam logic [2:0] OP_UDIV  = 3'b100;
    localparam logic [2:0] OP_SDIV  = 3'b101;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    // Bit positions inside flags, matching the ALUFlags ordering {N,Z,C,V}.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Reserved encodings fold onto MUL so the rest of the unit sees only five ops.
    function automatic logic [2:0] norm_op(input logic [2:0] op_in);
        logic [2:0] res;
        case (op_in)
            OP_UMULL, OP_SMULL, OP_UDIV, OP_SDIV: res = op_in;
            default:                              res = OP_MUL;
        endcase
        return res;
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op_in);
        return (op_in == OP_SMULL) || (op_in == OP_SDIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator: val_o = neg_i ? -val_i : val_i.
module muldiv_negate #(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);

    // Invert-and-increment when negation is requested, pass through otherwise.
    always_comb begin
        val_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit with start/busy/done handshake.
module iter_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH - 1);

    state_e                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic [WIDTH-1:0]       a_raw_q, a_raw_d;
    logic [WIDTH-1:0]       mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       res_lo_q, res_lo_d;
    logic [WIDTH-1:0]       res_hi_q, res_hi_d;
    logic [3:0]             flags_q, flags_d;
    logic                   dbz_q, dbz_d;

    logic [2:0]             op_norm;
    logic                   in_signed;
    logic [WIDTH-1:0]       mag_a_in, mag_b_in;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;
    logic                   is_div, is_long;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH-1:0]       div_diff;
    logic                   div_ge;

    assign op_norm   = norm_op(op);
    assign in_signed = is_signed_op(op_norm);
    assign is_div    = (op_q == OP_UDIV) || (op_q == OP_SDIV);
    assign is_long   = (op_q == OP_UMULL) || (op_q == OP_SMULL);

    muldiv_negate #(.W(WIDTH)) u_neg_a (
        .neg_i (in_signed & a[WIDTH-1]),
        .val_i (a),
        .val_o (mag_a_in)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_b (
        .neg_i (in_signed & b[WIDTH-1]),
        .val_i (b),
        .val_o (mag_b_in)
    );

    // Sign flops are only ever set for signed ops, so these are no-ops for unsigned work.
    muldiv_negate #(.W(2*WIDTH)) u_neg_prod (
        .neg_i (sign_a_q ^ sign_b_q),
        .val_i (acc_q),
        .val_o (prod_fix)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_quo (
        .neg_i (sign_a_q ^ sign_b_q),
        .val_i (acc_q[WIDTH-1:0]),
        .val_o (quo_fix)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_rem (
        .neg_i (sign_a_q),
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .val_o (rem_fix)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH edges, FIX and DONE one edge each.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == '0) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = (state_q == StRun) || (state_q == StFix);
        done = (state_q == StDone);
    end

    // Datapath next-state: operand latch, shift-add / restoring-divide step, sign fix-up.
    always_comb begin
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_raw_d  = a_raw_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        dbz_d    = dbz_q;

        // Multiply: add multiplicand into the high half when the low bit is set, shift right.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b_q});
        div_diff  = div_shift[WIDTH-1:0] - mag_b_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    op_d     = op_norm;
                    sign_a_d = in_signed & a[WIDTH-1];
                    sign_b_d = in_signed & b[WIDTH-1];
                    a_raw_d  = a;
                    mag_b_d  = mag_b_in;
                    acc_d    = {{WIDTH{1'b0}}, mag_a_in};
                    cnt_d    = CntInit;
                end
            end
            StRun: begin
                if (is_div) begin
                    acc_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            StFix: begin
                dbz_d   = 1'b0;
                flags_d = '0;
                if (is_div) begin
                    if (mag_b_q == '0) begin
                        res_lo_d = '0;
                        res_hi_d = a_raw_q;
                        dbz_d    = 1'b1;
                    end else begin
                        res_lo_d = quo_fix;
                        res_hi_d = rem_fix;
                    end
                    // Only MinVal / -1 overflows; the datapath already yields MinVal rem 0.
                    flags_d[FLAG_V] = (op_q == OP_SDIV) && sign_b_q && (mag_b_q == WIDTH'(1))
                                      && (a_raw_q == MinVal);
                end else begin
                    res_lo_d = prod_fix[WIDTH-1:0];
                    res_hi_d = is_long ? prod_fix[2*WIDTH-1:WIDTH] : '0;
                end
                if (is_long) begin
                    flags_d[FLAG_N] = res_hi_d[WIDTH-1];
                    flags_d[FLAG_Z] = ({res_hi_d, res_lo_d} == '0);
                end else begin
                    flags_d[FLAG_N] = res_lo_d[WIDTH-1];
                    flags_d[FLAG_Z] = (res_lo_d == '0);
                end
                flags_d[FLAG_C] = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_raw_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            dbz_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_raw_q  <= a_raw_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign flags       = flags_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed self-checking bench for iter_muldiv_unit at WIDTH=32.
module tb_iter_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int edges;

    always #5 clk = ~clk;

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .flags       (flags),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current (negedge) time; the next rising edge is the start edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Returns in the done cycle; optionally pokes start with other operands mid-run.
    task automatic wait_done(input string tag, input int intrude_at, output int n);
        int busy_cycles;
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b0;
        op    = OP_SDIV;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_0000;
        n     = 0;
        chk({tag, ".busy_after_start"}, 64'(busy), 64'd1);
        while (!done && n < 200) begin
            if (busy) busy_cycles++;
            if (n == intrude_at) begin
                start = 1'b1;
                op    = OP_MUL;
                a     = 32'd3;
                b     = 32'd3;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(W + 1));
        chk({tag, ".busy_cycles"}, 64'(busy_cycles), 64'(W + 1));
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] lo, input logic [W-1:0] hi,
                           input logic [3:0] fl, input logic dz);
        chk({tag, ".result_lo"}, 64'(result_lo), 64'(lo));
        chk({tag, ".result_hi"}, 64'(result_hi), 64'(hi));
        chk({tag, ".flags"}, 64'(flags), 64'(fl));
        chk({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(dz));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        #1 reset = 1'b1;
        #2;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk_res("reset", 32'h0, 32'h0, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // MUL 7*6, also confirm done is a single-cycle pulse.
        @(negedge clk);
        issue(OP_MUL, 32'd7, 32'd6);
        wait_done("mul", -1, edges);
        chk_res("mul", 32'd42, 32'd0, 4'b0000, 1'b0);
        @(negedge clk);
        chk("mul.done_pulse", 64'(done), 64'd0);
        chk("mul.idle_busy", 64'(busy), 64'd0);

        @(negedge clk);
        issue(OP_SMULL, 32'hFFFF_FFFE, 32'd3);
        wait_done("smull", -1, edges);
        chk_res("smull", 32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000, 1'b0);

        @(negedge clk);
        issue(OP_UMULL, 32'hFFFF_FFFE, 32'd3);
        wait_done("umull", -1, edges);
        chk_res("umull", 32'hFFFF_FFFA, 32'h0000_0002, 4'b0000, 1'b0);

        // Start pulsed during RUN must be ignored.
        @(negedge clk);
        issue(OP_UDIV, 32'd100, 32'd7);
        wait_done("udiv", 5, edges);
        chk_res("udiv", 32'd14, 32'd2, 4'b0000, 1'b0);

        @(negedge clk);
        issue(OP_SDIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("sdiv", -1, edges);
        chk_res("sdiv", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000, 1'b0);

        @(negedge clk);
        issue(OP_UDIV, 32'd55, 32'd0);
        wait_done("udiv0", -1, edges);
        chk_res("udiv0", 32'd0, 32'd55, 4'b0100, 1'b1);

        @(negedge clk);
        issue(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("sdiv_ovf", -1, edges);
        chk_res("sdiv_ovf", 32'h8000_0000, 32'h0, 4'b1001, 1'b0);

        // Back-to-back: second request held in the DONE cycle.
        @(negedge clk);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_done("b2b_first", -1, edges);
        chk_res("b2b_first", 32'h0, 32'h0, 4'b0100, 1'b0);
        issue(OP_SMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("b2b_second", -1, edges);
        chk_res("b2b_second", 32'd1, 32'd0, 4'b0000, 1'b0);

        // Reserved op executes as plain MUL.
        @(negedge clk);
        issue(3'b111, 32'hFFFF_FFFF, 32'd2);
        wait_done("rsvd", -1, edges);
        chk_res("rsvd", 32'hFFFF_FFFE, 32'h0, 4'b1000, 1'b0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        issue(OP_MUL, 32'd7, 32'd6);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid.busy_before", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.done", 64'(done), 64'd0);
        chk_res("rst_mid", 32'h0, 32'h0, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(OP_MUL, 32'd3, 32'd5);
        wait_done("post_rst", -1, edges);
        chk_res("post_rst", 32'd15, 32'd0, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
